// File: rtl/reg_writeback_unit_if.sv
// Bus bundle between the result producers (ALU and load paths), the
// register-block write port and the decode-side forwarding lookup.
// The write unit takes the master view; the surrounding pipeline takes slave.
interface reg_writeback_unit_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_rd;

  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_reg;
  logic [31:0] ld_word;
  logic        ld_byte_op;
  logic [1:0]  ld_byte_sel;
  logic        ld_signed;

  logic        regWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regDst;

  logic [4:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  logic        busy;

  modport master (
    input  alu_valid, alu_reg, alu_data, alu_rd,
    input  ld_valid, ld_reg, ld_word, ld_byte_op, ld_byte_sel, ld_signed,
    input  fwd_reg,
    output alu_ready, ld_ready,
    output regWrite, write_reg, write_data, regDst,
    output fwd_hit, fwd_data, busy
  );

  modport slave (
    output alu_valid, alu_reg, alu_data, alu_rd,
    output ld_valid, ld_reg, ld_word, ld_byte_op, ld_byte_sel, ld_signed,
    output fwd_reg,
    input  alu_ready, ld_ready,
    input  regWrite, write_reg, write_data, regDst,
    input  fwd_hit, fwd_data, busy
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Write-side master for the 32x32 register block. ALU and load results are
// queued in arrival order (load first when both arrive together) and each is
// replayed as a SETUP / STROBE / HOLD write so address and data are stable
// around the strobe. Writes to $zero are swallowed at the handshake, and a
// combinational lookup exposes the youngest pending value for any register.
module reg_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_writeback_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [PTR_W:0] DEPTH_W = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_W   = (PTR_W+1)'(1);

  state_t state_q, state_d;

  logic [4:0]       q_reg_q  [DEPTH];
  logic [31:0]      q_data_q [DEPTH];
  logic             q_dst_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic [4:0]       write_reg_q;
  logic [31:0]      write_data_q;
  logic             write_dst_q;

  logic [PTR_W:0]   free_slots;
  logic             ld_rdy, alu_rdy;
  logic             ld_push, alu_push, pop;
  logic [PTR_W:0]   push_cnt;
  logic [PTR_W-1:0] alu_slot;
  logic             load_head;
  logic [7:0]       ld_byte;
  logic [31:0]      ld_data;
  logic             fwd_hit_c;
  logic [31:0]      fwd_data_c;
  logic [PTR_W-1:0] fwd_idx;

  // Readiness is judged on the registered fill level only, so a pop at the
  // coming edge never lets a producer in early; the load path gets the last slot.
  always_comb begin
    free_slots = DEPTH_W - count_q;
    ld_rdy     = (free_slots != '0);
    alu_rdy    = (free_slots > ONE_W) || ((free_slots == ONE_W) && !bus.ld_valid);
    ld_push    = bus.ld_valid  && ld_rdy  && (bus.ld_reg  != 5'd0);
    alu_push   = bus.alu_valid && alu_rdy && (bus.alu_reg != 5'd0);
    push_cnt   = (PTR_W+1)'(ld_push) + (PTR_W+1)'(alu_push);
    alu_slot   = wr_ptr_q + PTR_W'(ld_push);
    pop        = (state_q == STROBE);
  end

  // Load results are shaped here so the queue only ever holds final write data.
  always_comb begin
    ld_byte = bus.ld_word[{bus.ld_byte_sel, 3'b000} +: 8];
    if (!bus.ld_byte_op) begin
      ld_data = bus.ld_word;
    end else if (bus.ld_signed) begin
      ld_data = {{24{ld_byte[7]}}, ld_byte};
    end else begin
      ld_data = {24'h0, ld_byte};
    end
  end

  // Pending-write queue: load entry lands ahead of an ALU entry from the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_reg_q[i]  <= '0;
        q_data_q[i] <= '0;
        q_dst_q[i]  <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (ld_push) begin
        q_reg_q[wr_ptr_q]  <= bus.ld_reg;
        q_data_q[wr_ptr_q] <= ld_data;
        q_dst_q[wr_ptr_q]  <= 1'b0;
      end
      if (alu_push) begin
        q_reg_q[alu_slot]  <= bus.alu_reg;
        q_data_q[alu_slot] <= bus.alu_data;
        q_dst_q[alu_slot]  <= bus.alu_rd;
      end
      wr_ptr_q <= wr_ptr_q + push_cnt[PTR_W-1:0];
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_q + push_cnt - (PTR_W+1)'(pop);
    end
  end

  // Write sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write sequencer next state: one register-block write every three cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = (count_q != '0) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write port address/data only move when a new write enters SETUP.
  assign load_head = (state_d == SETUP) && (state_q != SETUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg_q  <= '0;
      write_data_q <= '0;
      write_dst_q  <= 1'b0;
    end else if (load_head) begin
      write_reg_q  <= q_reg_q[rd_ptr_q];
      write_data_q <= q_data_q[rd_ptr_q];
      write_dst_q  <= q_dst_q[rd_ptr_q];
    end
  end

  // Forwarding: start from the in-flight write, then let each younger queued match override it.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx    = '0;
    if ((state_q != IDLE) && (write_reg_q == bus.fwd_reg)) begin
      fwd_hit_c  = 1'b1;
      fwd_data_c = write_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (q_reg_q[fwd_idx] == bus.fwd_reg)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = q_data_q[fwd_idx];
      end
    end
    if (bus.fwd_reg == 5'd0) begin
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
    end
  end

  // Output decode: the strobe is a pure function of state so reset drops it at once.
  always_comb begin
    bus.regWrite   = (state_q == STROBE);
    bus.write_reg  = write_reg_q;
    bus.write_data = write_data_q;
    bus.regDst     = write_dst_q;
    bus.alu_ready  = alu_rdy;
    bus.ld_ready   = ld_rdy;
    bus.fwd_hit    = fwd_hit_c;
    bus.fwd_data   = fwd_data_c;
    bus.busy       = (count_q != '0) || (state_q != IDLE);
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit. A scoreboard of accepted writes is
// kept in a plain queue and checked against the DUT at every falling edge,
// alongside literal checks of latency, byte extension and forwarding.
module tb_reg_writeback_unit;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic        dst;
  } wr_t;

  logic clk;
  logic rst_n;
  reg_writeback_unit_if bus ();

  reg_writeback_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int  assertCount = 0;
  int  failCount   = 0;
  wr_t pending[$];
  wr_t holdEntry;
  bit  holdWin     = 0;
  int  sinceStrobe = 100;
  bit  sawAluLow   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // What a load must write, from the byte-lane rules in plain arithmetic.
  function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic bop,
                                            input logic [1:0] sel, input logic sg);
    int unsigned b;
    if (!bop) return w;
    b = (w >> (8 * int'(sel))) & 32'hFF;
    if (sg && b >= 128) return 32'hFFFF_FF00 | b;
    return b;
  endfunction

  // Scoreboard: predicts ready/busy/forwarding from pending writes, checks
  // each strobe against the oldest pending write, then books new acceptances.
  always @(negedge clk) begin
    int  freeSlots;
    bit  expLd, expAlu, expHit;
    logic [31:0] expData;
    wr_t e;
    if (!rst_n) begin
      pending.delete();
      holdWin     = 0;
      sinceStrobe = 100;
    end else begin
      freeSlots = DEPTH - pending.size();
      expLd  = (freeSlots >= 1);
      expAlu = (freeSlots >= 2) || (freeSlots == 1 && !bus.ld_valid);
      checkOutput("ld_ready",  {31'b0, bus.ld_ready},  {31'b0, expLd});
      checkOutput("alu_ready", {31'b0, bus.alu_ready}, {31'b0, expAlu});
      checkOutput("busy", {31'b0, bus.busy}, {31'b0, (pending.size() != 0) || holdWin});
      if (bus.alu_valid && !bus.alu_ready) sawAluLow = 1;

      expHit = 0;
      expData = '0;
      if (bus.fwd_reg != 5'd0) begin
        for (int i = pending.size() - 1; i >= 0 && !expHit; i--) begin
          if (pending[i].r == bus.fwd_reg) begin
            expHit = 1;
            expData = pending[i].d;
          end
        end
        if (!expHit && holdWin && holdEntry.r == bus.fwd_reg) begin
          expHit = 1;
          expData = holdEntry.d;
        end
      end
      checkOutput("fwd_hit",  {31'b0, bus.fwd_hit}, {31'b0, expHit});
      checkOutput("fwd_data", bus.fwd_data, expData);

      sinceStrobe++;
      holdWin = 0;
      if (bus.regWrite) begin
        checkOutput("strobe_spacing_ok", {31'b0, sinceStrobe >= 3}, 32'd1);
        sinceStrobe = 0;
        if (pending.size() == 0) begin
          checkOutput("unexpected_write_reg", {27'b0, bus.write_reg}, 32'd0);
        end else begin
          e = pending.pop_front();
          checkOutput("write_reg",  {27'b0, bus.write_reg}, {27'b0, e.r});
          checkOutput("write_data", bus.write_data, e.d);
          checkOutput("regDst",     {31'b0, bus.regDst}, {31'b0, e.dst});
          holdEntry = e;
          holdWin   = 1;
        end
      end

      if (expLd && bus.ld_valid && bus.ld_reg != 5'd0)
        pending.push_back('{bus.ld_reg,
                            modelLoad(bus.ld_word, bus.ld_byte_op, bus.ld_byte_sel, bus.ld_signed),
                            1'b0});
      if (expAlu && bus.alu_valid && bus.alu_reg != 5'd0)
        pending.push_back('{bus.alu_reg, bus.alu_data, bus.alu_rd});
    end
  end

  // Offers one ALU and/or one load result and holds each until its handshake.
  task automatic applyStimulus(input logic aV, input logic [4:0] aR, input logic [31:0] aD, input logic aRd,
                               input logic lV, input logic [4:0] lR, input logic [31:0] lW,
                               input logic lB, input logic [1:0] lS, input logic lSg);
    bit aPend = aV, lPend = lV, aTake, lTake;
    int guard = 0;
    bus.alu_valid = aV; bus.alu_reg = aR; bus.alu_data = aD; bus.alu_rd = aRd;
    bus.ld_valid = lV; bus.ld_reg = lR; bus.ld_word = lW;
    bus.ld_byte_op = lB; bus.ld_byte_sel = lS; bus.ld_signed = lSg;
    while ((aPend || lPend) && guard < 200) begin
      @(negedge clk);
      aTake = aPend && bus.alu_ready;
      lTake = lPend && bus.ld_ready;
      @(posedge clk); #1;
      if (aTake) begin aPend = 0; bus.alu_valid = 1'b0; end
      if (lTake) begin lPend = 0; bus.ld_valid  = 1'b0; end
      guard++;
    end
    if (aPend || lPend) begin
      checkOutput("handshake_timeout", 32'd1, 32'd0);
      bus.alu_valid = 1'b0;
      bus.ld_valid  = 1'b0;
    end
  endtask

  // Waits for the next strobe, returning how many falling edges it took.
  task automatic waitForWrite(output int cyc, output logic [4:0] r, output logic [31:0] d, output logic dst);
    cyc = 0; r = '0; d = '0; dst = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.regWrite) begin
        cyc = i; r = bus.write_reg; d = bus.write_data; dst = bus.regDst;
        break;
      end
    end
    if (cyc == 0) checkOutput("write_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    if (!idle) checkOutput("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    logic [4:0]  r;
    logic [31:0] d;
    logic        dst;

    rst_n = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0; bus.alu_rd = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_reg = '0; bus.ld_word = '0;
    bus.ld_byte_op = 1'b0; bus.ld_byte_sel = '0; bus.ld_signed = 1'b0;
    bus.fwd_reg = 5'd8;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_regWrite",   {31'b0, bus.regWrite},  32'd0);
    checkOutput("rst_write_reg",  {27'b0, bus.write_reg}, 32'd0);
    checkOutput("rst_write_data", bus.write_data,         32'd0);
    checkOutput("rst_regDst",     {31'b0, bus.regDst},    32'd0);
    checkOutput("rst_alu_ready",  {31'b0, bus.alu_ready}, 32'd1);
    checkOutput("rst_ld_ready",   {31'b0, bus.ld_ready},  32'd1);
    checkOutput("rst_fwd_hit",    {31'b0, bus.fwd_hit},   32'd0);
    checkOutput("rst_fwd_data",   bus.fwd_data,           32'd0);
    checkOutput("rst_busy",       {31'b0, bus.busy},      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ALU write and its latency
    $display("[TB] ALU write latency");
    applyStimulus(1, 5'd8, 32'h0000_0005, 1, 0, 5'd0, 32'h0, 0, 2'd0, 0);
    waitForWrite(cyc, r, d, dst);
    checkOutput("t1_latency", cyc, 32'd3);
    checkOutput("t1_reg",  {27'b0, r}, 32'd8);
    checkOutput("t1_data", d, 32'h0000_0005);
    checkOutput("t1_dst",  {31'b0, dst}, 32'd1);
    waitIdle();

    // lb / lbu byte extraction
    $display("[TB] byte loads");
    applyStimulus(0, 5'd0, 32'h0, 0, 1, 5'd3, 32'h1280_3456, 1, 2'd2, 1);
    waitForWrite(cyc, r, d, dst);
    checkOutput("t2_lb_data", d, 32'hFFFF_FF80);
    checkOutput("t2_lb_dst",  {31'b0, dst}, 32'd0);
    waitIdle();
    applyStimulus(0, 5'd0, 32'h0, 0, 1, 5'd3, 32'h1280_3456, 1, 2'd2, 0);
    waitForWrite(cyc, r, d, dst);
    checkOutput("t2_lbu_data", d, 32'h0000_0080);
    waitIdle();
    applyStimulus(0, 5'd0, 32'h0, 0, 1, 5'd4, 32'hCAFE_F00D, 1, 2'd0, 1);
    waitForWrite(cyc, r, d, dst);
    checkOutput("t2_lb_lane0", d, 32'h0000_000D);
    waitIdle();

    // $zero destination is swallowed
    $display("[TB] zero register write");
    applyStimulus(1, 5'd0, 32'h0000_DEAD, 1, 0, 5'd0, 32'h0, 0, 2'd0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("t3_no_write", {31'b0, bus.regWrite}, 32'd0);
      checkOutput("t3_not_busy", {31'b0, bus.busy},     32'd0);
    end
    @(posedge clk); #1;

    // Both producers every cycle: back-pressure, ordering, no loss
    $display("[TB] saturated producers");
    bus.fwd_reg = 5'd21;
    sawAluLow = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(1, 5'(10 + i), 32'hA000_0000 + i, 1,
                        1, 5'(20 + i), 32'hB000_0000 + i, 0, 2'd0, 0);
      end
      begin
        waitForWrite(cyc, r, d, dst);
        checkOutput("t4_first_is_load", {27'b0, r}, 32'd20);
        checkOutput("t4_first_data", d, 32'hB000_0000);
      end
    join
    waitIdle();
    checkOutput("t4_alu_backpressure", {31'b0, sawAluLow}, 32'd1);

    // Forwarding picks the youngest pending value
    $display("[TB] forwarding");
    bus.fwd_reg = 5'd9;
    applyStimulus(1, 5'd9, 32'h1, 0, 0, 5'd0, 32'h0, 0, 2'd0, 0);
    applyStimulus(1, 5'd9, 32'h2, 0, 0, 5'd0, 32'h0, 0, 2'd0, 0);
    @(negedge clk);
    checkOutput("t5_fwd_hit",  {31'b0, bus.fwd_hit}, 32'd1);
    checkOutput("t5_fwd_data", bus.fwd_data, 32'h2);
    @(posedge clk); #1;
    waitIdle();
    @(negedge clk);
    checkOutput("t5_fwd_hit_after",  {31'b0, bus.fwd_hit}, 32'd0);
    checkOutput("t5_fwd_data_after", bus.fwd_data, 32'h0);
    @(posedge clk); #1;

    // Reset during the strobe aborts the write
    $display("[TB] reset during strobe");
    applyStimulus(1, 5'd7, 32'h77, 1, 0, 5'd0, 32'h0, 0, 2'd0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("t6_in_strobe", {31'b0, bus.regWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_strobe_drop", {31'b0, bus.regWrite}, 32'd0);
    checkOutput("t6_busy_drop",   {31'b0, bus.busy},     32'd0);
    checkOutput("t6_reg_cleared", {27'b0, bus.write_reg}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("t6_quiet_write", {31'b0, bus.regWrite}, 32'd0);
      checkOutput("t6_quiet_busy",  {31'b0, bus.busy},     32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(1, 5'd31, 32'h1234_5678, 0, 1, 5'd30, 32'h8899_AABB, 1, 2'd3, 1);
    waitIdle();

    checkOutput("drain_empty", pending.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
